bresenham_tracer: RTL and testbench

BRESENHAM_TRACER -- requirements
Module: bresenham_tracer

---
 rtl/bresenham_tracer.sv | 179 +++++++++++++++++
 tb/tb_bresenham_tracer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bresenham_tracer.sv
// Purpose : traces one sensor beam across an occupancy grid, issuing one cell write per
//           cell from the origin (x0,y0) to the hit cell (x1,y1) using Bresenham's line walk.
// Latency : start accepted at edge N, first write strobe possible in cycle N+2; done pulses
//           in the cycle after the final write, together with ready.
// Backpressure: occ_busy high freezes the walk (no strobe, x/y/err held) until it drops.
//
// Ports   : clock/reset (async, active low); start + x0/y0/x1/y1 request a beam (latched
//           on the accepting edge); occ_busy stalls writes; x/y/cell_is_free/bresenham_we
//           form the grid write; ready = able to accept start; done = end-of-beam pulse.
// Option  : define BRESENHAM_SKIP_ORIGIN_EN to suppress the write of the origin cell
//           (the walk still spends one cycle stepping past it); a degenerate beam still
//           writes its single hit cell.
module bresenham_tracer #(
   parameter int X_WIDTH = 5,
   parameter int Y_WIDTH = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [X_WIDTH-1:0] x0,
   input  logic [Y_WIDTH-1:0] y0,
   input  logic [X_WIDTH-1:0] x1,
   input  logic [Y_WIDTH-1:0] y1,
   input  logic               occ_busy,
   output logic [X_WIDTH-1:0] x,
   output logic [Y_WIDTH-1:0] y,
   output logic               cell_is_free,
   output logic               bresenham_we,
   output logic               ready,
   output logic               done
);

   // Two guard bits: one for sign, one so that 2*err never overflows.
   localparam int W = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;

   typedef enum logic [1:0] {IDLE, SETUP, STEP, FINISH} state_t;

   state_t                state_q, state_d;
   logic [X_WIDTH-1:0]    x0_q, x0_d, x1_q, x1_d, x_q, x_d;
   logic [Y_WIDTH-1:0]    y0_q, y0_d, y1_q, y1_d, y_q, y_d;
   logic signed [W-1:0]   dx_q, dx_d, dy_q, dy_d, err_q, err_d;
   logic                  sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
   logic                  origin_skip;

   logic signed [W-1:0]   x0_e, x1_e, y0_e, y1_e;
   logic signed [W-1:0]   dx_c, dy_c, e2, err_n;
   logic                  at_hit, accept, advance;

   assign x0_e = signed'({{(W-X_WIDTH){1'b0}}, x0_q});
   assign x1_e = signed'({{(W-X_WIDTH){1'b0}}, x1_q});
   assign y0_e = signed'({{(W-Y_WIDTH){1'b0}}, y0_q});
   assign y1_e = signed'({{(W-Y_WIDTH){1'b0}}, y1_q});

   // dx is the positive column span, dy the negated row span.
   assign dx_c = (x1_e >= x0_e) ? (x1_e - x0_e) : (x0_e - x1_e);
   assign dy_c = (y1_e >= y0_e) ? (y0_e - y1_e) : (y1_e - y0_e);
   assign e2   = err_q <<< 1;

   assign at_hit = (x_q == x1_q) && (y_q == y1_q);
   // Ready in FINISH as well, so ready rises together with done.
   assign ready  = (state_q == IDLE) || (state_q == FINISH);
   assign accept = start && ready;

`ifdef BRESENHAM_SKIP_ORIGIN_EN
   logic skip_q, skip_d;
   assign origin_skip = skip_q;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) skip_q <= 1'b0;
      else        skip_q <= skip_d;
   end
   always_comb begin
      skip_d = skip_q;
      // Arm only for a real line; a degenerate beam must still write its hit cell.
      if (state_q == SETUP)     skip_d = !((x0_q == x1_q) && (y0_q == y1_q));
      else if (state_q == STEP) skip_d = 1'b0;
   end
`else
   assign origin_skip = 1'b0;
`endif

   assign bresenham_we = (state_q == STEP) && !occ_busy && !origin_skip;
   assign cell_is_free = (state_q == STEP) && !at_hit;
   assign done         = (state_q == FINISH);
   assign x            = x_q;
   assign y            = y_q;

   always_comb begin
      state_d  = state_q;
      x0_d     = x0_q;
      y0_d     = y0_q;
      x1_d     = x1_q;
      y1_d     = y1_q;
      x_d      = x_q;
      y_d      = y_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      err_d    = err_q;
      sx_neg_d = sx_neg_q;
      sy_neg_d = sy_neg_q;
      err_n    = err_q;
      advance  = 1'b0;

      case (state_q)
         IDLE, FINISH: begin
            state_d = IDLE;
            if (accept) begin
               x0_d    = x0;
               y0_d    = y0;
               x1_d    = x1;
               y1_d    = y1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            dx_d     = dx_c;
            dy_d     = dy_c;
            err_d    = dx_c + dy_c;
            sx_neg_d = (x1_q < x0_q);
            sy_neg_d = (y1_q < y0_q);
            x_d      = x0_q;
            y_d      = y0_q;
            state_d  = STEP;
         end
         STEP: begin
            // A skipped origin needs no grid slot, so it steps regardless of occ_busy.
            if (origin_skip) begin
               advance = 1'b1;
            end else if (!occ_busy) begin
               if (at_hit) state_d = FINISH;
               else        advance = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (advance) begin
         if (e2 >= dy_q) begin
            err_n = err_n + dy_q;
            x_d   = sx_neg_q ? (x_q - 1'b1) : (x_q + 1'b1);
         end
         if (e2 <= dx_q) begin
            err_n = err_n + dx_q;
            y_d   = sy_neg_q ? (y_q - 1'b1) : (y_q + 1'b1);
         end
         err_d = err_n;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         x0_q     <= '0;
         y0_q     <= '0;
         x1_q     <= '0;
         y1_q     <= '0;
         x_q      <= '0;
         y_q      <= '0;
         dx_q     <= '0;
         dy_q     <= '0;
         err_q    <= '0;
         sx_neg_q <= 1'b0;
         sy_neg_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         x1_q     <= x1_d;
         y1_q     <= y1_d;
         x_q      <= x_d;
         y_q      <= y_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         err_q    <= err_d;
         sx_neg_q <= sx_neg_d;
         sy_neg_q <= sy_neg_d;
      end
   end

endmodule

// File: tb/tb_bresenham_tracer.sv
// Directed bench for bresenham_tracer: each task runs one beam scenario and compares the
// logged write stream against hand-computed cell lists.
module tb_bresenham_tracer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       occ_busy = 1'b0;
   logic [4:0] x0 = '0, x1 = '0, x;
   logic [3:0] y0 = '0, y1 = '0, y;
   logic       cell_is_free, bresenham_we, ready, done;

`ifdef BRESENHAM_SKIP_ORIGIN_EN
   localparam int SKIP = 1;
`else
   localparam int SKIP = 0;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cyc = -1;
   int acc_cyc = 0;
   int skip_eff = 0;
   logic ready_at_done = 1'b0;
   int wx[$], wy[$], wf[$], wc[$];
   int ex[$], ey[$], ef[$];

   bresenham_tracer #(.X_WIDTH(5), .Y_WIDTH(4)) dut (
      .clock(clock), .reset(reset), .start(start),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1), .occ_busy(occ_busy),
      .x(x), .y(y), .cell_is_free(cell_is_free), .bresenham_we(bresenham_we),
      .ready(ready), .done(done)
   );

   always #5 clock = ~clock;

   // Log every write strobe and the done pulse, sampled mid-cycle.
   always @(negedge clock) begin
      cyc = cyc + 1;
      if (bresenham_we === 1'b1) begin
         wx.push_back(int'(x));
         wy.push_back(int'(y));
         wf.push_back(int'(cell_is_free));
         wc.push_back(cyc);
      end
      if (done === 1'b1) begin
         done_cyc = cyc;
         ready_at_done = ready;
      end
   end

   task automatic clear_log();
      wx.delete(); wy.delete(); wf.delete(); wc.delete();
      ex.delete(); ey.delete(); ef.delete();
      done_cyc = -1;
   endtask

   // Drop the origin from the expectation when the build suppresses it (not for 1-cell beams).
   task automatic apply_skip();
      skip_eff = (SKIP == 1 && ex.size() > 1) ? 1 : 0;
      if (skip_eff == 1) begin
         void'(ex.pop_front()); void'(ey.pop_front()); void'(ef.pop_front());
      end
   endtask

   task automatic start_trace(input int ax, input int ay, input int bx, input int by);
      @(posedge clock); #1;
      x0 = 5'(ax); y0 = 4'(ay); x1 = 5'(bx); y1 = 4'(by);
      start = 1'b1;
      @(posedge clock); #1;
      acc_cyc = cyc;
      start = 1'b0;
      // Scramble the inputs: the trace must use the values latched at acceptance.
      x0 = ~x0; y0 = ~y0; x1 = ~x1; y1 = ~y1;
   endtask

   task automatic wait_done(input string nm);
      for (int i = 0; i < 300 && done_cyc < 0; i++) @(posedge clock);
      checks++;
      if (done_cyc < 0) begin
         failures++;
         $display("FAIL %s_timeout done never seen, writes=%0d", nm, wx.size());
      end
      repeat (2) @(posedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++; if (x !== 5'd0)           begin failures++; $display("FAIL reset_x got=%0d exp=0", x); end
      checks++; if (y !== 4'd0)           begin failures++; $display("FAIL reset_y got=%0d exp=0", y); end
      checks++; if (ready !== 1'b1)       begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
      checks++; if (done !== 1'b0)        begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (bresenham_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bresenham_we); end
      checks++; if (cell_is_free !== 1'b0) begin failures++; $display("FAIL reset_free got=%b exp=0", cell_is_free); end
      reset = 1'b1;
      repeat (2) @(posedge clock);
   endtask

   task automatic test_horizontal();
      clear_log();
      ex = '{0, 1, 2, 3, 4}; ey = '{0, 0, 0, 0, 0}; ef = '{1, 1, 1, 1, 0};
      apply_skip();
      start_trace(0, 0, 4, 0);
      wait_done("horiz");
      checks++;
      if (wx.size() != ex.size()) begin failures++; $display("FAIL horiz_count got=%0d exp=%0d", wx.size(), ex.size()); end
      for (int i = 0; i < ex.size() && i < wx.size(); i++) begin
         checks++;
         if (wx[i] != ex[i] || wy[i] != ey[i] || wf[i] != ef[i]) begin
            failures++;
            $display("FAIL horiz_cell%0d got=(%0d,%0d,f%0d) exp=(%0d,%0d,f%0d)", i, wx[i], wy[i], wf[i], ex[i], ey[i], ef[i]);
         end
      end
      if (wc.size() > 0) begin
         checks++;
         if (wc[0] != acc_cyc + 2 + skip_eff) begin failures++; $display("FAIL horiz_latency got=%0d exp=%0d", wc[0] - acc_cyc, 2 + skip_eff); end
         checks++;
         if (wc[wc.size()-1] - wc[0] != wc.size() - 1) begin failures++; $display("FAIL horiz_consecutive span=%0d exp=%0d", wc[wc.size()-1] - wc[0], wc.size() - 1); end
         checks++;
         if (done_cyc != wc[wc.size()-1] + 1) begin failures++; $display("FAIL horiz_done_cycle got=%0d exp=%0d", done_cyc, wc[wc.size()-1] + 1); end
      end
      checks++;
      if (ready_at_done !== 1'b1) begin failures++; $display("FAIL horiz_ready_at_done got=%b exp=1", ready_at_done); end
   endtask

   task automatic test_diagonal();
      clear_log();
      ex = '{3, 2, 1, 0}; ey = '{2, 3, 4, 5}; ef = '{1, 1, 1, 0};
      apply_skip();
      start_trace(3, 2, 0, 5);
      wait_done("diag");
      checks++;
      if (wx.size() != ex.size()) begin failures++; $display("FAIL diag_count got=%0d exp=%0d", wx.size(), ex.size()); end
      for (int i = 0; i < ex.size() && i < wx.size(); i++) begin
         checks++;
         if (wx[i] != ex[i] || wy[i] != ey[i] || wf[i] != ef[i]) begin
            failures++;
            $display("FAIL diag_cell%0d got=(%0d,%0d,f%0d) exp=(%0d,%0d,f%0d)", i, wx[i], wy[i], wf[i], ex[i], ey[i], ef[i]);
         end
      end
   endtask

   task automatic test_steep();
      int steps;
      clear_log();
      ex = '{2, 2, 2, 2, 2, 3, 3, 3, 3, 3};
      ey = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
      ef = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      apply_skip();
      start_trace(2, 0, 3, 9);
      wait_done("steep");
      checks++;
      if (wx.size() != ex.size()) begin failures++; $display("FAIL steep_count got=%0d exp=%0d", wx.size(), ex.size()); end
      for (int i = 0; i < ex.size() && i < wx.size(); i++) begin
         checks++;
         if (wx[i] != ex[i] || wy[i] != ey[i] || wf[i] != ef[i]) begin
            failures++;
            $display("FAIL steep_cell%0d got=(%0d,%0d,f%0d) exp=(%0d,%0d,f%0d)", i, wx[i], wy[i], wf[i], ex[i], ey[i], ef[i]);
         end
      end
      steps = 0;
      for (int i = 1; i < wx.size(); i++) if (wx[i] != wx[i-1]) steps++;
      checks++;
      if (steps != 1 - skip_eff * 0) begin failures++; $display("FAIL steep_xsteps got=%0d exp=1", steps); end
   endtask

   task automatic test_degenerate();
      clear_log();
      ex = '{5}; ey = '{5}; ef = '{0};
      apply_skip();
      start_trace(5, 5, 5, 5);
      wait_done("degen");
      checks++;
      if (wx.size() != 1) begin failures++; $display("FAIL degen_count got=%0d exp=1", wx.size()); end
      if (wx.size() > 0) begin
         checks++;
         if (wx[0] != 5 || wy[0] != 5 || wf[0] != 0) begin
            failures++;
            $display("FAIL degen_cell got=(%0d,%0d,f%0d) exp=(5,5,f0)", wx[0], wy[0], wf[0]);
         end
         checks++;
         if (wc[0] != acc_cyc + 2) begin failures++; $display("FAIL degen_latency got=%0d exp=2", wc[0] - acc_cyc); end
      end
   endtask

   task automatic test_stall();
      int hx;
      clear_log();
      ex = '{0, 1, 2, 3, 4}; ey = '{0, 0, 0, 0, 0}; ef = '{1, 1, 1, 1, 0};
      apply_skip();
      start_trace(0, 0, 4, 0);
      for (int i = 0; i < 50 && wx.size() < 2; i++) begin @(posedge clock); #1; end
      checks++;
      if (wx.size() < 2) begin failures++; $display("FAIL stall_prewrites got=%0d exp=2", wx.size()); end
      occ_busy = 1'b1;
      hx = ex[1] + 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock); #1;
         checks++;
         if (bresenham_we !== 1'b0 || x !== 5'(hx) || y !== 4'd0) begin
            failures++;
            $display("FAIL stall_hold%0d got we=%b (%0d,%0d) exp we=0 (%0d,0)", i, bresenham_we, x, y, hx);
         end
      end
      @(posedge clock); #1;
      occ_busy = 1'b0;
      wait_done("stall");
      checks++;
      if (wx.size() != ex.size()) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", wx.size(), ex.size()); end
      for (int i = 0; i < ex.size() && i < wx.size(); i++) begin
         checks++;
         if (wx[i] != ex[i] || wy[i] != ey[i] || wf[i] != ef[i]) begin
            failures++;
            $display("FAIL stall_cell%0d got=(%0d,%0d,f%0d) exp=(%0d,%0d,f%0d)", i, wx[i], wy[i], wf[i], ex[i], ey[i], ef[i]);
         end
      end
      if (wc.size() > 2) begin
         checks++;
         if (wc[2] - wc[1] != 4) begin failures++; $display("FAIL stall_gap got=%0d exp=4", wc[2] - wc[1]); end
      end
   endtask

   task automatic test_reset_mid();
      clear_log();
      start_trace(0, 0, 7, 3);
      for (int i = 0; i < 50 && wx.size() < 2; i++) begin @(posedge clock); #1; end
      reset = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b1 || bresenham_we !== 1'b0 || done !== 1'b0 || x !== 5'd0 || y !== 4'd0) begin
         failures++;
         $display("FAIL rstmid_async got ready=%b we=%b done=%b (%0d,%0d) exp ready=1 we=0 done=0 (0,0)", ready, bresenham_we, done, x, y);
      end
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (6) @(posedge clock);
      #1;
      checks++;
      if (wx.size() != 2) begin failures++; $display("FAIL rstmid_nowrites got=%0d exp=2", wx.size()); end
      checks++;
      if (ready !== 1'b1 || done_cyc != -1) begin failures++; $display("FAIL rstmid_idle got ready=%b done_cyc=%0d exp ready=1 done_cyc=-1", ready, done_cyc); end
      clear_log();
      ex = '{1, 1, 1}; ey = '{1, 2, 3}; ef = '{1, 1, 0};
      apply_skip();
      start_trace(1, 1, 1, 3);
      wait_done("fresh");
      checks++;
      if (wx.size() != ex.size()) begin failures++; $display("FAIL fresh_count got=%0d exp=%0d", wx.size(), ex.size()); end
      for (int i = 0; i < ex.size() && i < wx.size(); i++) begin
         checks++;
         if (wx[i] != ex[i] || wy[i] != ey[i] || wf[i] != ef[i]) begin
            failures++;
            $display("FAIL fresh_cell%0d got=(%0d,%0d,f%0d) exp=(%0d,%0d,f%0d)", i, wx[i], wy[i], wf[i], ex[i], ey[i], ef[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_horizontal();
      test_diagonal();
      test_steep();
      test_degenerate();
      test_stall();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
